// File: rtl/times_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module  : times_table_sweeper
// Brief   : Built-in self-test driver/checker for a 3x3-bit multiplier memory.
//           Walks all 64 (a,b) pairs, strobes a read for each one, samples the
//           returned product LATENCY edges later and tallies mismatches.
// Revision: 1.0 - initial release
// ============================================================================
module times_table_sweeper #(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic       read,
  input  logic [5:0] result,
  output logic       busy,
  output logic       done,
  output logic [6:0] err_count,
  output logic       fail_seen,
  output logic [5:0] first_fail
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_TAIL  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  // Value of the latency counter on the cycle before the sample edge.
  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [5:0] idx;
  logic [2:0] lat_cnt;
  logic       sample;
  logic       last;
  logic [5:0] expected;
  logic       mismatch;

  // The edge that closes this cycle is the sample edge for the current pair.
  // With LATENCY=1 that is the edge leaving ISSUE, so WAIT is never entered.
  assign sample   = ((state == S_ISSUE) && (LATENCY == 1)) ||
                    ((state == S_WAIT) && (lat_cnt == LAT_M1));
  assign last     = (idx == 6'd63);
  assign expected = {3'b000, idx[5:3]} * {3'b000, idx[2:0]};
  assign mismatch = (result != expected);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. After the final sample a one-cycle TAIL keeps the done
  // pulse on the same LATENCY+1 cadence as the reads (done at S+64*(L+1)).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (sample) state_nxt = last ? S_TAIL : S_GAP;
        else        state_nxt = S_WAIT;
      end
      S_WAIT:  if (sample) state_nxt = last ? S_TAIL : S_GAP;
      S_GAP:   state_nxt = S_ISSUE;
      S_TAIL:  state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from registered state only; a/b come from the index.
  always_comb begin
    read = (state == S_ISSUE);
    busy = (state == S_ISSUE) || (state == S_WAIT) ||
           (state == S_GAP)   || (state == S_TAIL);
    done = (state == S_FIN);
    a    = idx[5:3];
    b    = idx[2:0];
  end

  // Pair index, latency counter and mismatch bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 6'd0;
      lat_cnt    <= 3'd0;
      err_count  <= 7'd0;
      fail_seen  <= 1'b0;
      first_fail <= 6'd0;
    end else begin
      if ((state == S_IDLE) && start) begin
        idx        <= 6'd0;
        err_count  <= 7'd0;
        fail_seen  <= 1'b0;
        first_fail <= 6'd0;
      end

      if (state == S_ISSUE)     lat_cnt <= 3'd1;
      else if (state == S_WAIT) lat_cnt <= lat_cnt + 3'd1;

      if (sample) begin
        if (mismatch) begin
          err_count <= err_count + 7'd1;
          if (!fail_seen) begin
            first_fail <= idx;
            fail_seen  <= 1'b1;
          end
        end
        // Index stops at 63; a/b keep showing (7,7) until the next start.
        if (!last) idx <= idx + 6'd1;
      end
    end
  end

endmodule
`default_nettype wire
